// File: rtl/xgcd_mon_pkg.sv
// Shared constants and types for the XGCD run monitor: register map, CTRL/STATUS bit
// positions and the run-tracking FSM state type.
package xgcd_mon_pkg;

  localparam logic [9:0] OffId      = 10'd0;
  localparam logic [9:0] OffCtrl    = 10'd1;
  localparam logic [9:0] OffStatus  = 10'd2;
  localparam logic [9:0] OffLastLat = 10'd3;
  localparam logic [9:0] OffMaxLat  = 10'd4;
  localparam logic [9:0] OffRunCnt  = 10'd5;
  localparam logic [9:0] OffTimeout = 10'd6;

  localparam logic [31:0] MonId = 32'h584D4F4E;

  localparam int unsigned CtrlEn     = 0;
  localparam int unsigned CtrlIeDone = 1;
  localparam int unsigned CtrlIeTo   = 2;

  localparam int unsigned StatBusy    = 0;
  localparam int unsigned StatDone    = 1;
  localparam int unsigned StatTimeout = 2;
  localparam int unsigned StatOverlap = 3;

  typedef enum logic {
    StIdle = 1'b0,
    StRun  = 1'b1
  } mon_state_e;

endpackage

// File: rtl/xgcd_mon_edge.sv
// Rising-edge detector: compares the live input with a registered copy.
module xgcd_mon_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic in_i,
  output logic rise_o
);

  logic in_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      in_q <= 1'b0;
    end else begin
      in_q <= in_i;
    end
  end

  assign rise_o = in_i & ~in_q;

endmodule

// File: rtl/xgcd_run_monitor.sv
// Run-latency monitor for the XGCD core with APB statistics/status and merged interrupt.
// Optional macro XGCD_MON_IRQ_PASS_EN folds the core IRQ_IN into MON_IRQ.
module xgcd_run_monitor
  import xgcd_mon_pkg::*;
#(
  parameter int unsigned CNT_WIDTH       = 32,
  parameter logic [31:0] TIMEOUT_DEFAULT = 32'd0
) (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic [31:0] PADDR,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  input  logic        START_IN,
  input  logic        DONE_IN,
  input  logic        IRQ_IN,
  output logic        MON_IRQ
);

  localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CntMax = '1;

  logic [9:0] offset;
  logic       wr_en, rd_en;
  logic       start_ev, done_ev;

  mon_state_e           state_q, state_d;
  logic [2:0]           ctrl_q, ctrl_d;
  logic                 done_q, done_d, to_q, to_d, ovl_q, ovl_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d, last_q, last_d, max_q, max_d;
  logic [CNT_WIDTH-1:0] runs_q, runs_d, tmo_q, tmo_d;
  logic [31:0]          prdata_q, prdata_d, status_rd;
  logic                 irq_q, irq_d;
  logic                 set_done, set_to, set_ovl;
  logic [3:0]           w1c;

  assign offset  = PADDR[11:2];
  assign wr_en   = PSEL & ~PENABLE & PWRITE;
  assign rd_en   = PSEL & ~PENABLE & ~PWRITE;
  assign PREADY  = 1'b1;
  assign PSLVERR = PSEL & PENABLE & (offset > 10'd6);
  assign PRDATA  = prdata_q;
  assign MON_IRQ = irq_q;

  logic unused_paddr;
  assign unused_paddr = ^{PADDR[31:12], PADDR[1:0]};

  xgcd_mon_edge u_start_edge (
    .clk_i  (CLK),
    .rst_ni (RESETn),
    .in_i   (START_IN),
    .rise_o (start_ev)
  );

  xgcd_mon_edge u_done_edge (
    .clk_i  (CLK),
    .rst_ni (RESETn),
    .in_i   (DONE_IN),
    .rise_o (done_ev)
  );

  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    max_d    = max_q;
    runs_d   = runs_q;
    tmo_d    = tmo_q;
    set_done = 1'b0;
    set_to   = 1'b0;
    set_ovl  = 1'b0;
    w1c      = '0;

    // Register writes first so that completion updates below override clears.
    if (wr_en) begin
      case (offset)
        OffCtrl:    ctrl_d = PWDATA[2:0];
        OffStatus:  w1c = PWDATA[3:0];
        OffMaxLat:  max_d = '0;
        OffRunCnt:  runs_d = '0;
        OffTimeout: tmo_d = PWDATA[CNT_WIDTH-1:0];
        default:    ;
      endcase
    end

    case (state_q)
      StIdle: begin
        if (ctrl_q[CtrlEn] && start_ev) begin
          state_d = StRun;
          cnt_d   = CntOne;
        end
      end
      StRun: begin
        if (!ctrl_q[CtrlEn]) begin
          state_d = StIdle;
        end else if (done_ev) begin
          last_d   = cnt_q;
          max_d    = (cnt_q > max_q) ? cnt_q : max_q;
          runs_d   = (runs_q == CntMax) ? runs_q : runs_q + CntOne;
          set_done = 1'b1;
          if (start_ev) begin
            cnt_d = CntOne;
          end else begin
            state_d = StIdle;
          end
        end else if (start_ev) begin
          set_ovl = 1'b1;
          cnt_d   = CntOne;
        end else if ((tmo_q != '0) && (cnt_q == tmo_q)) begin
          set_to  = 1'b1;
          state_d = StIdle;
        end else if (cnt_q != CntMax) begin
          cnt_d = cnt_q + CntOne;
        end
      end
      default: state_d = StIdle;
    endcase

    done_d = (done_q & ~w1c[StatDone]) | set_done;
    to_d   = (to_q & ~w1c[StatTimeout]) | set_to;
    ovl_d  = (ovl_q & ~w1c[StatOverlap]) | set_ovl;
  end

  always_comb begin
    status_rd              = '0;
    status_rd[StatBusy]    = (state_q == StRun);
    status_rd[StatDone]    = done_q;
    status_rd[StatTimeout] = to_q;
    status_rd[StatOverlap] = ovl_q;

    prdata_d = prdata_q;
    if (rd_en) begin
      case (offset)
        OffId:      prdata_d = MonId;
        OffCtrl:    prdata_d = {29'd0, ctrl_q};
        OffStatus:  prdata_d = status_rd;
        OffLastLat: prdata_d = 32'(last_q);
        OffMaxLat:  prdata_d = 32'(max_q);
        OffRunCnt:  prdata_d = 32'(runs_q);
        OffTimeout: prdata_d = 32'(tmo_q);
        default:    prdata_d = '0;
      endcase
    end

    irq_d = (done_q & ctrl_q[CtrlIeDone]) | (to_q & ctrl_q[CtrlIeTo]);
`ifdef XGCD_MON_IRQ_PASS_EN
    irq_d = irq_d | IRQ_IN;
`endif
  end

`ifndef XGCD_MON_IRQ_PASS_EN
  logic unused_irq;
  assign unused_irq = IRQ_IN;
`endif

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q  <= StIdle;
      ctrl_q   <= '0;
      done_q   <= 1'b0;
      to_q     <= 1'b0;
      ovl_q    <= 1'b0;
      cnt_q    <= '0;
      last_q   <= '0;
      max_q    <= '0;
      runs_q   <= '0;
      tmo_q    <= TIMEOUT_DEFAULT[CNT_WIDTH-1:0];
      prdata_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      done_q   <= done_d;
      to_q     <= to_d;
      ovl_q    <= ovl_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      max_q    <= max_d;
      runs_q   <= runs_d;
      tmo_q    <= tmo_d;
      prdata_q <= prdata_d;
      irq_q    <= irq_d;
    end
  end

endmodule

// File: tb/tb_xgcd_run_monitor.sv
// Directed plus randomized bench for xgcd_run_monitor; expected latencies come from edge stamps.
module tb_xgcd_run_monitor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] paddr = '0;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [31:0] pwdata = '0;
  logic [31:0] prdata;
  logic        pready, pslverr;
  logic        start_in = 1'b0, done_in = 1'b0, irq_in = 1'b0;
  logic        mon_irq;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  xgcd_run_monitor dut (
    .CLK      (clk),
    .RESETn   (rst_n),
    .PADDR    (paddr),
    .PSEL     (psel),
    .PENABLE  (penable),
    .PWRITE   (pwrite),
    .PWDATA   (pwdata),
    .PRDATA   (prdata),
    .PREADY   (pready),
    .PSLVERR  (pslverr),
    .START_IN (start_in),
    .DONE_IN  (done_in),
    .IRQ_IN   (irq_in),
    .MON_IRQ  (mon_irq)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic apb_write(input int off, input logic [31:0] data);
    paddr = 32'(off) << 2; pwdata = data; pwrite = 1'b1; psel = 1'b1; penable = 1'b0;
    tick();
    penable = 1'b1;
    tick();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input int off, output logic [31:0] data, output logic err);
    paddr = 32'(off) << 2; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
    tick();
    penable = 1'b1;
    #1;
    data = prdata;
    err  = pslverr;
    tick();
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic read_chk(input string tag, input int off, input logic [31:0] exp);
    logic [31:0] d;
    logic        e;
    apb_read(off, d, e);
    check(tag, d, exp);
  endtask

  // Start pulse sampled at edge T, done pulse sampled at edge T+n; returns edge stamps.
  task automatic run(input int n, output int st, output int dn);
    start_in = 1'b1;
    tick();
    st = cyc;
    start_in = 1'b0;
    repeat (n - 1) tick();
    done_in = 1'b1;
    tick();
    dn = cyc;
    done_in = 1'b0;
    tick();
  endtask

  initial begin
    logic [31:0] d;
    logic        e;
    int          st, dn, lat, tmo, n;
    int          exp_last, exp_max, exp_runs;

    #12;
    check("reset_prdata", prdata, 32'h0);
    check("reset_irq", {31'd0, mon_irq}, 32'h0);
    rst_n = 1'b1;
    tick();
    check("pready", {31'd0, pready}, 32'h1);
    read_chk("id", 0, 32'h584D4F4E);
    read_chk("reset_status", 2, 32'h0);
    read_chk("reset_timeout", 6, 32'h0);
    apb_read(7, d, e);
    check("unmapped_data", d, 32'h0);
    check("unmapped_slverr", {31'd0, e}, 32'h1);
    apb_read(3, d, e);
    check("mapped_slverr", {31'd0, e}, 32'h0);

    // Basic runs.
    apb_write(1, 32'h1);
    run(10, st, dn);
    read_chk("lat10_last", 3, 32'(dn - st));
    read_chk("lat10_max", 4, 32'd10);
    read_chk("lat10_runs", 5, 32'd1);
    read_chk("lat10_status", 2, 32'h2);
    run(4, st, dn);
    read_chk("lat4_last", 3, 32'(dn - st));
    read_chk("lat4_max", 4, 32'd10);
    read_chk("lat4_runs", 5, 32'd2);
    apb_write(4, 32'h0);
    read_chk("max_clear", 4, 32'h0);

    // Timeout boundary: N == TIMEOUT succeeds, longer run times out.
    apb_write(6, 32'd5);
    apb_write(1, 32'h5);
    apb_write(2, 32'hE);
    run(5, st, dn);
    read_chk("n_eq_tmo_last", 3, 32'd5);
    read_chk("n_eq_tmo_status", 2, 32'h2);
    apb_write(2, 32'hE);
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    repeat (4) tick();
    check("irq_pre_to", {31'd0, mon_irq}, 32'h0);
    tick();
    check("irq_at_to", {31'd0, mon_irq}, 32'h0);
    tick();
    check("irq_after_to", {31'd0, mon_irq}, 32'h1);
    read_chk("to_status", 2, 32'h4);
    read_chk("to_runs", 5, 32'd3);
    apb_write(2, 32'h4);
    check("irq_cleared", {31'd0, mon_irq}, 32'h0);
    read_chk("to_status_clr", 2, 32'h0);
    apb_write(6, 32'd0);
    apb_write(1, 32'h1);

    // Overlap: starts at T and T+3, done at T+5.
    start_in = 1'b1; tick(); start_in = 1'b0;
    tick(); tick();
    start_in = 1'b1; tick(); st = cyc; start_in = 1'b0;
    tick();
    done_in = 1'b1; tick(); dn = cyc; done_in = 1'b0;
    tick();
    read_chk("ovl_status", 2, 32'hA);
    read_chk("ovl_last", 3, 32'(dn - st));
    apb_write(2, 32'hE);

    // Done coincident with a new start keeps the monitor busy.
    start_in = 1'b1; tick(); st = cyc; start_in = 1'b0;
    tick(); tick();
    start_in = 1'b1; done_in = 1'b1; tick(); dn = cyc;
    start_in = 1'b0; done_in = 1'b0;
    read_chk("coin_runs", 5, 32'd5);
    read_chk("coin_status", 2, 32'h3);
    read_chk("coin_last", 3, 32'(dn - st));
    apb_write(1, 32'h0);
    tick();
    read_chk("abort_status", 2, 32'h2);
    read_chk("abort_runs", 5, 32'd5);
    read_chk("abort_last", 3, 32'(dn - st));

    // Randomized runs against a latency/timeout model.
    exp_last = dn - st;
    exp_max  = 5;
    exp_runs = 5;
    apb_write(1, 32'h1);
    for (int i = 0; i < 10; i++) begin
      n   = int'($urandom_range(1, 14));
      tmo = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 12));
      apb_write(6, 32'(tmo));
      apb_write(2, 32'hE);
      repeat ($urandom_range(0, 3)) tick();
      run(n, st, dn);
      lat = dn - st;
      if (tmo != 0 && lat > tmo) begin
        read_chk("rnd_status_to", 2, 32'h4);
      end else begin
        exp_last = lat;
        exp_runs++;
        if (lat > exp_max) exp_max = lat;
        read_chk("rnd_status_ok", 2, 32'h2);
      end
      read_chk("rnd_last", 3, 32'(exp_last));
      read_chk("rnd_max", 4, 32'(exp_max));
      read_chk("rnd_runs", 5, 32'(exp_runs));
    end
    apb_write(6, 32'd0);
    apb_write(2, 32'hE);
    apb_write(5, 32'h0);
    read_chk("runs_clear", 5, 32'h0);

    // Core interrupt pass-through.
    irq_in = 1'b1;
    tick();
`ifdef XGCD_MON_IRQ_PASS_EN
    check("irq_pass", {31'd0, mon_irq}, 32'h1);
`else
    check("irq_nopass", {31'd0, mon_irq}, 32'h0);
`endif
    irq_in = 1'b0;
    tick();
    check("irq_idle", {31'd0, mon_irq}, 32'h0);

    // Reset in the middle of a run.
    read_chk("id_again", 0, 32'h584D4F4E);
    start_in = 1'b1; tick(); start_in = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check("midrst_prdata", prdata, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    read_chk("midrst_status", 2, 32'h0);
    read_chk("midrst_ctrl", 1, 32'h0);
    read_chk("midrst_last", 3, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
